mem_copy_engine: RTL
====================

# mem_copy_engine

Block-copy initiator that drives the data-memory port from the requester side: it reads `length` words starting at `src_base` and writes them to consecutive words starting at `dst_base`. It sits between the control logic (or a test harness) and the single-port, positive-edge data memory. It honours that memory's one-cycle registered read latency and its read-old-data-on-write behaviour. A running XOR checksum of the copied words is kept for software and bench verification.

## Interface

Parameters:
- `width`, 32: data and address width; addresses are word addresses.
- `lenWidth`, 16: width of the length and counter fields.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request a copy; sampled only in IDLE.
- `abort`, input, 1: terminate the current copy early.
- `src_base`, input, width: first source word address; captured on accepted start.
- `dst_base`, input, width: first destination word address; captured on accepted start.
- `length`, input, lenWidth: number of words to copy; captured on accepted start.
- `busy`, output, 1: high in RD, WR and DONE.
- `done`, output, 1: one-cycle pulse in the DONE state.
- `words_copied`, output, lenWidth: count of completed writes in the current or last copy.
- `checksum`, output, width: XOR of all words written in the current or last copy.
- `mem_address`, output, width: registered address to the memory.
- `mem_writeEnable`, output, 1: registered write strobe to the memory.
- `mem_dataIn`, output, width: write data to the memory; combinational.
- `mem_dataOut`, input, width: registered read data from the memory, valid the cycle after the address was presented.

## Operation

- **States:** IDLE, RD, WR, DONE. Reset forces IDLE.
- **Reset values:** `busy`=0, `done`=0, `words_copied`=0, `checksum`=0, `mem_address`=0, `mem_writeEnable`=0, and `mem_dataIn`=0 (because the state is not WR).
- **IDLE:** on `start`=1:
  - capture `src_base`, `dst_base` and `length`;
  - clear `words_copied` and `checksum`;
  - if `length`=0, go to DONE;
  - otherwise go to RD with `mem_address`=src and `mem_writeEnable`=0.
- **RD:** the memory samples the source address at the closing edge.
  - At that edge, go to WR with `mem_address`=current dst and `mem_writeEnable`=1.
- **WR:** `mem_dataIn` = `mem_dataOut`, which holds the word read in RD.
  - At the closing edge, the memory writes that word.
  - Also at that edge: `checksum` ^= `mem_dataOut`; `words_copied` += 1; src += 1; dst += 1.
  - If `words_copied`+1 == `length`, go to DONE with `mem_writeEnable`=0.
  - Otherwise go to RD with `mem_address`=next src and `mem_writeEnable`=0.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE. `mem_writeEnable`=0.
- **Outside WR:** `mem_dataIn` = 0.
- **Abort:**
  - `abort`=1 sampled in RD: go to DONE with no write for that word.
  - `abort`=1 sampled in WR: the write in progress completes and is counted, then go to DONE.
  - `abort` in IDLE or DONE is ignored. `abort` has priority over normal sequencing.
- **Start while busy:** `start` in RD, WR or DONE is ignored; the captured parameters do not change.
- **Address arithmetic:** src and dst increment modulo 2^width. Wrap from all-ones to 0 is legal and not flagged.
- **Overlap:** the copy is strictly ascending, one word at a time.
  - If dst > src and the ranges overlap, later reads return already-copied data. This is the defined behaviour, not an error.
  - dst == src is legal: each word is rewritten with itself.
- **Hold:** `words_copied` and `checksum` hold their final values until the next accepted start.

## Timing

- Start is accepted at edge E0.
  - Word k (k = 0..N−1) is read in cycle 2k+1 and written in cycle 2k+2 after E0.
  - `done` is high in cycle 2N+1. `busy` falls, and a new start can be accepted, in cycle 2N+2.
- `length`=0: `done` is high in cycle 1, with no memory write.
- Throughput is 2 cycles per word. The address changes every cycle while busy.
- The WR-cycle memory read (dst old value) is ignored.
- Asynchronous `reset_n` low at any point aborts immediately:
  - all outputs go to their reset values without waiting for the clock;
  - a partially completed copy stays in memory.

## Test plan

- **Basic copy:** mem[0..3]=1,2,3,4; start with src=0, dst=100, length=4.
  - Expect mem[100..103]=1,2,3,4.
  - Expect `done` pulse 9 cycles after the start edge, `words_copied`=4, `checksum`=0x4.
- **Zero length:** length=0 → `done` in cycle 1, `mem_writeEnable` never high, `words_copied`=0, `checksum`=0.
- **Overlapping forward copy:** mem[10]=0xA, mem[11]=0xB; src=10, dst=11, length=2.
  - Expect mem[11]=0xA, mem[12]=0xA, `checksum`=0.
- **Abort in WR of word 1 (length 5):** exactly 2 words written, `words_copied`=2, `done` one cycle later, no further writes.
- **Start ignored mid-copy, then reset:**
  - Pulse `start` with different bases mid-copy → no effect on the copy.
  - Drive `reset_n` low mid-WR between clock edges → `mem_writeEnable`=0 and `busy`=0 immediately; FSM in IDLE after release.
- **Address wrap:** with width=32, src=0xFFFFFFFF, length=2 → second read at address 0, and the copy completes normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block-copy initiator for a single-port, positive-edge data memory
// with one-cycle registered read latency. Copies `length` words from src_base to
// dst_base in strictly ascending order, one read cycle then one write cycle per word,
// and keeps an XOR checksum of the words written.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start, abort          - start a copy (IDLE only) / terminate a copy early
//   src_base, dst_base    - first source / destination word address (captured on start)
//   length                - number of words to copy (captured on start)
//   busy, done            - high in RD/WR/DONE / one-cycle pulse in DONE
//   words_copied          - completed writes in the current or last copy
//   checksum              - XOR of all words written in the current or last copy
//   mem_address           - registered word address to the memory
//   mem_writeEnable       - registered write strobe to the memory
//   mem_dataIn            - write data to the memory (read data forwarded in WR, else 0)
//   mem_dataOut           - registered read data from the memory
module mem_copy_engine #(
  parameter int unsigned width    = 32,
  parameter int unsigned lenWidth = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [width-1:0]    src_base,
  input  logic [width-1:0]    dst_base,
  input  logic [lenWidth-1:0] length,
  output logic                busy,
  output logic                done,
  output logic [lenWidth-1:0] words_copied,
  output logic [width-1:0]    checksum,
  output logic [width-1:0]    mem_address,
  output logic                mem_writeEnable,
  output logic [width-1:0]    mem_dataIn,
  input  logic [width-1:0]    mem_dataOut
);

  localparam logic [width-1:0]    AddrOne = {{(width-1){1'b0}}, 1'b1};
  localparam logic [lenWidth-1:0] CntOne  = {{(lenWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e              state;
  logic [width-1:0]    src_addr;
  logic [width-1:0]    dst_addr;
  logic [lenWidth-1:0] len_reg;

  logic [width-1:0]    src_next;
  logic [width-1:0]    dst_next;
  logic [lenWidth-1:0] words_next;
  logic                last_word;

  // Addresses wrap modulo 2^width by plain truncation.
  assign src_next   = src_addr + AddrOne;
  assign dst_next   = dst_addr + AddrOne;
  assign words_next = words_copied + CntOne;
  assign last_word  = (words_next == len_reg);

  // In WR the memory's registered output still holds the word fetched in RD.
  assign mem_dataIn = (state == StWr) ? mem_dataOut : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= StIdle;
      src_addr        <= '0;
      dst_addr        <= '0;
      len_reg         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      words_copied    <= '0;
      checksum        <= '0;
      mem_address     <= '0;
      mem_writeEnable <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            src_addr        <= src_base;
            dst_addr        <= dst_base;
            len_reg         <= length;
            words_copied    <= '0;
            checksum        <= '0;
            mem_writeEnable <= 1'b0;
            busy            <= 1'b1;
            if (length == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state       <= StRd;
              mem_address <= src_base;
            end
          end
        end
        StRd: begin
          if (abort) begin
            // Word not yet written: drop it entirely.
            state <= StDone;
            done  <= 1'b1;
          end else begin
            state           <= StWr;
            mem_address     <= dst_addr;
            mem_writeEnable <= 1'b1;
          end
        end
        StWr: begin
          // The write completes at this edge regardless of abort, so it is counted.
          checksum        <= checksum ^ mem_dataOut;
          words_copied    <= words_next;
          src_addr        <= src_next;
          dst_addr        <= dst_next;
          mem_writeEnable <= 1'b0;
          if (abort || last_word) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            state       <= StRd;
            mem_address <= src_next;
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
